// File: rtl/sram_1w1r_bwe.sv
// One-write/one-read behavioural SRAM with per-lane write masks, collision bypass,
// an optional output register and a post-reset zero-fill sweep gated by 'ready'.
module sram_1w1r_bwe #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int WMASK_WIDTH = 4,
  parameter bit BYPASS      = 1'b1,
  parameter bit OUT_REG     = 1'b0,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic                   clk0,
  input  logic                   rst0,
  output logic                   ready,
  input  logic                   csb0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid
);

  localparam int LW = DATA_WIDTH / WMASK_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic                  collide;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data;

  assign ready       = (state == ST_READY);
  assign wr_in_range = ({1'b0, addr0} < DEPTH);
  assign rd_in_range = ({1'b0, addr1} < DEPTH);
  // A write arriving together with reset is dropped, hence the rst0 term.
  assign wr_en       = ready && !csb0 && !rst0 && wr_in_range;
  assign rd_en       = ready && !csb1;
  assign collide     = wr_en && rd_en && (addr0 == addr1);

  always_comb begin
    wr_bits = '0;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      wr_bits[i*LW +: LW] = {LW{wmask0[i]}};
    end
  end

  assign rd_word = rd_in_range ? mem[addr1] : '0;
  assign rd_data = (BYPASS && collide) ? ((din0 & wr_bits) | (rd_word & ~wr_bits)) : rd_word;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state   <= ST_RESET;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_RESET: state <= INIT_CLEAR ? ST_CLEAR : ST_READY;
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) state <= ST_READY;
        end
        ST_READY: state <= ST_READY;
        default:  state <= ST_RESET;
      endcase
    end
  end

  // Storage has no reset; contents change only through the sweep or the write port.
  always_ff @(posedge clk0) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      mem[addr0] <= (din0 & wr_bits) | (mem[addr0] & ~wr_bits);
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] pipe_data;
      logic                  pipe_valid;

      always_ff @(posedge clk0) begin
        if (rst0) begin
          pipe_data   <= '0;
          pipe_valid  <= 1'b0;
          dout1       <= '0;
          dout1_valid <= 1'b0;
        end else begin
          pipe_valid  <= rd_en;
          if (rd_en) pipe_data <= rd_data;
          dout1_valid <= pipe_valid;
          if (pipe_valid) dout1 <= pipe_data;
        end
      end
    end else begin : g_out_direct
      always_ff @(posedge clk0) begin
        if (rst0) begin
          dout1       <= '0;
          dout1_valid <= 1'b0;
        end else begin
          dout1_valid <= rd_en;
          if (rd_en) dout1 <= rd_data;
        end
      end
    end
  endgenerate

endmodule
